// File: rtl/fft_frame_loader.sv
// fft_frame_loader: frame packer and timing source for the 16-point CORDIC FFT.
// It accepts complex samples over a valid/ready handshake and packs 16 of them
// into flat real/imaginary buses. It then holds the frame for LATENCY cycles and
// strobes result_strobe on the cycle when the FFT outputs belong to this frame.
// Optional build macro: FFT_PRESCALE_EN stores every sample arithmetically
// shifted right by one to give headroom through the butterfly stages.
module fft_frame_loader #(
   parameter int N_POINTS = 16,
   parameter int LATENCY  = 64,
   parameter int CNT_W    = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [15:0]         in_x,
   input  logic signed [15:0]         in_y,
   input  logic                       flush,
   output logic [N_POINTS*16-1:0]     x_bus,
   output logic [N_POINTS*16-1:0]     y_bus,
   output logic                       frame_valid,
   output logic                       result_strobe,
   output logic [CNT_W-1:0]           frame_count
);

   localparam int DATA_W = 16;
   localparam int IDX_W  = $clog2(N_POINTS);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_POINTS - 1);
   localparam logic [7:0]       HOLD_LAST = 8'(LATENCY - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic [7:0]       hold_cnt, cnt_next;
   logic             wr_en;
   logic             frame_done;

   // Optional headroom shift applied to a sample before it is stored
   function automatic logic signed [DATA_W-1:0] prescale(input logic signed [DATA_W-1:0] s);
`ifdef FFT_PRESCALE_EN
      return s >>> 1;
`else
      return s;
`endif
   endfunction

   // Ready is a pure state decode so upstream never sees a path from in_valid
   assign in_ready = (state == FILL);

   // A frame is counted only when its hold window runs to completion
   assign frame_done = (state == HOLD) && (hold_cnt == HOLD_LAST) && !flush;

   // Next-state, write index and hold counter decode
   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = hold_cnt;
      wr_en      = 1'b0;
      case (state)
         FILL: begin
            if (flush) begin
               idx_next = '0;
            end else if (in_valid) begin
               wr_en = 1'b1;
               if (idx == IDX_LAST) begin
                  idx_next   = '0;
                  cnt_next   = '0;
                  state_next = HOLD;
               end else begin
                  idx_next = idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (flush || (hold_cnt == HOLD_LAST)) begin
               state_next = FILL;
            end else begin
               cnt_next = hold_cnt + 8'd1;
            end
         end
      endcase
   end

   // Control registers; strobe and frame_valid are registered from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= FILL;
         idx           <= '0;
         hold_cnt      <= '0;
         frame_valid   <= 1'b0;
         result_strobe <= 1'b0;
         frame_count   <= '0;
      end else begin
         state         <= state_next;
         idx           <= idx_next;
         hold_cnt      <= cnt_next;
         frame_valid   <= (state_next == HOLD);
         result_strobe <= (state_next == HOLD) && (cnt_next == HOLD_LAST);
         if (frame_done) begin
            frame_count <= frame_count + CNT_W'(1);
         end
      end
   end

   // Sample slots are overwritten in place; untouched slots keep old contents
   always_ff @(posedge clock) begin
      if (reset) begin
         x_bus <= '0;
         y_bus <= '0;
      end else if (wr_en) begin
         x_bus[{idx, 4'b0000} +: DATA_W] <= prescale(in_x);
         y_bus[{idx, 4'b0000} +: DATA_W] <= prescale(in_y);
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: table-driven frame with a scoreboard of expected
// frames, plus hand-written sequences for hold, flush and reset corner cases.
module tb_fft_frame_loader;

   localparam int LATENCY = 64;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [15:0]  in_x = '0;
   logic [15:0]  in_y = '0;
   logic         flush = 1'b0;
   logic [255:0] x_bus, y_bus;
   logic         frame_valid, result_strobe;
   logic [7:0]   frame_count;

   fft_frame_loader #(.N_POINTS(16), .LATENCY(LATENCY), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .flush(flush), .x_bus(x_bus), .y_bus(y_bus),
      .frame_valid(frame_valid), .result_strobe(result_strobe),
      .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [255:0] x;
      logic [255:0] y;
   } frame_t;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] ex;
      logic [15:0] ey;
   } vec_t;

   int           n_cmp = 0;
   int           n_bad = 0;
   frame_t       sb_q[$];
   logic [255:0] mx = '0, my = '0;
   int           midx = 0;
   logic [7:0]   exp_count = '0;
   logic         fv_prev = 1'b0;

   // Stored value of a sample: sign bit replicated into the vacated top bit
   function automatic logic [15:0] pre(input logic [15:0] v);
`ifdef FFT_PRESCALE_EN
      return {v[15], v[15:1]};
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      mx = '0;
      my = '0;
      midx = 0;
      exp_count = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_clear();
      check("rst_x_bus", x_bus, 256'd0);
      check("rst_y_bus", y_bus, 256'd0);
      check("rst_frame_valid", frame_valid, 1'b0);
      check("rst_strobe", result_strobe, 1'b0);
      check("rst_frame_count", frame_count, 8'd0);
      check("rst_in_ready", in_ready, 1'b1);
   endtask

   task automatic send_sample(input logic [15:0] x, input logic [15:0] y);
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      check("in_ready_fill", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      mx[midx*16 +: 16] = pre(x);
      my[midx*16 +: 16] = pre(y);
      midx++;
      if (midx == 16) begin
         sb_q.push_back('{x: mx, y: my});
         midx = 0;
      end
   endtask

   task automatic rand_gaps();
      while ($urandom_range(0, 9) >= 3) tick();
   endtask

   // Called on the first HOLD cycle; runs to the strobe and one cycle beyond
   task automatic wait_strobe(input bit hammer);
      int cyc;
      cyc = 1;
      check("fv_after_last_accept", frame_valid, 1'b1);
      while (!result_strobe && cyc < 400) begin
         if (hammer) begin
            in_valid = 1'b1;
            in_x = 16'($urandom);
            in_y = 16'($urandom);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_x_frozen", x_bus, mx);
            check("hold_y_frozen", y_bus, my);
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("strobe_seen", result_strobe, 1'b1);
      check("strobe_latency", cyc, LATENCY);
      check("fv_at_strobe", frame_valid, 1'b1);
      check("in_ready_at_strobe", in_ready, 1'b0);
      tick();
      exp_count++;
      check("strobe_one_cycle", result_strobe, 1'b0);
      check("fv_after_strobe", frame_valid, 1'b0);
      check("in_ready_after_strobe", in_ready, 1'b1);
      check("frame_count", frame_count, exp_count);
      if (hammer) begin
         check("hold_no_write_x", x_bus, mx);
         check("hold_no_write_y", y_bus, my);
      end
   endtask

   // Scoreboard: every rising frame_valid must match the oldest pending frame
   always @(negedge clock) begin
      if (reset) begin
         fv_prev = 1'b0;
      end else begin
         if (frame_valid && !fv_prev) begin
            check("sb_frame_pending", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
               frame_t f;
               f = sb_q.pop_front();
               check("sb_x_bus", x_bus, f.x);
               check("sb_y_bus", y_bus, f.y);
            end
         end
         fv_prev = frame_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[16];
      int   seen;

      tbl[0]  = '{16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF};
      tbl[1]  = '{16'h0003, 16'hFFFD, 16'h0001, 16'hFFFE};
      tbl[2]  = '{16'h7FFF, 16'h8000, 16'h3FFF, 16'hC000};
      tbl[3]  = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
      tbl[4]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[5]  = '{16'h1234, 16'hEDCC, 16'h091A, 16'hF6E6};
      tbl[6]  = '{16'h0002, 16'hFFFE, 16'h0001, 16'hFFFF};
      tbl[7]  = '{16'h8001, 16'h7FFE, 16'hC000, 16'h3FFF};
      tbl[8]  = '{16'h0100, 16'hFF00, 16'h0080, 16'hFF80};
      tbl[9]  = '{16'hAAAA, 16'h5555, 16'hD555, 16'h2AAA};
      tbl[10] = '{16'h0005, 16'hFFFB, 16'h0002, 16'hFFFD};
      tbl[11] = '{16'hC000, 16'h4000, 16'hE000, 16'h2000};
      tbl[12] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
      tbl[13] = '{16'h7000, 16'h9000, 16'h3800, 16'hC800};
      tbl[14] = '{16'h00FF, 16'hFF01, 16'h007F, 16'hFF80};
      tbl[15] = '{16'h4321, 16'hBCDF, 16'h2190, 16'hDE6F};
`ifndef FFT_PRESCALE_EN
      for (int i = 0; i < 16; i++) begin
         tbl[i].ex = tbl[i].x;
         tbl[i].ey = tbl[i].y;
      end
`endif

      // Ramp frame with a hammered hold window
      do_reset();
      for (int k = 0; k < 16; k++) send_sample(16'(k), 16'(-k));
      check("x_slot0", x_bus[15:0], pre(16'd0));
      check("x_slot15", x_bus[255:240], pre(16'd15));
      check("y_slot1", y_bus[31:16], pre(16'hFFFF));
      wait_strobe(1'b1);

      // Table-driven frame with random gaps, then two random frames
      do_reset();
      for (int i = 0; i < 16; i++) begin
         rand_gaps();
         send_sample(tbl[i].x, tbl[i].y);
      end
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tbl_x%0d", i), x_bus[i*16 +: 16], tbl[i].ex);
         check($sformatf("tbl_y%0d", i), y_bus[i*16 +: 16], tbl[i].ey);
      end
      wait_strobe(1'b0);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 16; i++) begin
            rand_gaps();
            send_sample(16'($urandom), 16'($urandom));
         end
         wait_strobe(1'b0);
      end
      check("three_frames", frame_count, 8'd3);

      // Flush in FILL, coincident with a sample that must be dropped
      for (int i = 0; i < 5; i++) send_sample(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      in_valid = 1'b1;
      in_x = 16'hDEAD;
      in_y = 16'hBEEF;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      midx = 0;
      check("flush_fill_in_ready", in_ready, 1'b1);
      check("flush_fill_fv", frame_valid, 1'b0);
      for (int i = 0; i < 16; i++) send_sample(16'h3000 + 16'(i), 16'h4000 - 16'(i));
      check("after_fill_flush_slot0", x_bus[15:0], pre(16'h3000));
      wait_strobe(1'b0);

      // Flush at hold cycle 10
      for (int i = 0; i < 16; i++) send_sample(16'h0500 + 16'(i), 16'h0600 + 16'(i));
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_hold_fv", frame_valid, 1'b0);
      check("flush_hold_in_ready", in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < LATENCY + 16; i++) begin
         if (result_strobe) seen++;
         tick();
      end
      check("flush_no_strobe", seen, 0);
      check("flush_count_kept", frame_count, exp_count);
      for (int i = 0; i < 16; i++) send_sample(16'h7700 + 16'(i), 16'h8800 + 16'(i));
      check("after_hold_flush_slot0", x_bus[15:0], pre(16'h7700));
      wait_strobe(1'b0);

      // Reset after 7 accepts, then a clean frame
      for (int i = 0; i < 7; i++) send_sample(16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
      do_reset();
      for (int i = 0; i < 16; i++) send_sample(16'h0C00 + 16'(i), 16'hF000 + 16'(i));
      check("post_reset_slot0", x_bus[15:0], pre(16'h0C00));
      wait_strobe(1'b0);
      check("post_reset_count", frame_count, 8'd1);

      tick();
      check("sb_all_consumed", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
